sha256_msg_schedule: RTL and testbench

Message-schedule stage of the SHA-256 datapath. It reads one 512-bit padded block as 16 words from the message memory and expands it into the 64-word schedule W0..W63. It streams one word per cycle on `w_out`, with `w_valid` held high for exactly 64 contiguous cycles, and this directly drives the compression stage's `w_in`/`trigger_w`. It also supplies the round index used to address the K-constant memory, one cycle ahead of each word.

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_w_expand.sv | 15 +
 rtl/sha256_msg_schedule.sv | 118 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: control states, block geometry and the sigma helpers
// used by the message schedule (and by the compression stage).
package sha256_pkg;

  localparam int MSG_WORDS = 16;
  localparam int ROUNDS    = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: next W from the four window taps it depends on.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] w_new
);

  // Plain 32-bit adds: carries out of bit 31 are dropped by the width.
  assign w_new = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words, then expands to W0..W63,
// streaming one word per cycle with k_addr leading w_out by one cycle.
module sha256_msg_schedule #(
  parameter int MSG_WORDS = 16,
  parameter int ROUNDS    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] msg_mem_data,
  output logic [3:0]  msg_mem_address,
  output logic        msg_mem_enable,
  output logic [31:0] w_out,
  output logic        w_valid,
  output logic [5:0]  k_addr,
  output logic        busy,
  output logic        done
);
  import sha256_pkg::*;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;          // index of the word written this cycle
  logic [3:0]  addr_q, addr_d;
  logic        en_q, en_d;
  logic        mem_vld_q, mem_vld_d;  // memory data valid this cycle
  logic [31:0] w_q, w_d;
  logic        wv_q, wv_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] exp_word, new_word;
  logic        wr;

  sha256_w_expand u_expand (
    .w0    (win_q[0]),
    .w1    (win_q[1]),
    .w9    (win_q[9]),
    .w14   (win_q[14]),
    .w_new (exp_word)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    en_d      = 1'b0;
    mem_vld_d = en_q;
    w_d       = w_q;
    // The first EXPAND cycle still captures M15, so expansion starts with no bubble.
    wr        = mem_vld_q | (state_q == ST_EXPAND && cnt_q < 7'(ROUNDS));
    new_word  = mem_vld_q ? msg_mem_data : exp_word;
    wv_d      = wr;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

    if (wr) begin
      w_d   = new_word;
      cnt_d = cnt_q + 7'd1;
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = new_word;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          en_d    = 1'b1;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (addr_q == 4'(MSG_WORDS - 1)) begin
          state_d = ST_EXPAND;
          addr_d  = '0;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_q + 4'd1;
        end
      end
      ST_EXPAND: if (cnt_q == 7'(ROUNDS)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      mem_vld_q <= 1'b0;
      w_q       <= '0;
      wv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      mem_vld_q <= mem_vld_d;
      w_q       <= w_d;
      wv_q      <= wv_d;
    end
  end

  // The window is fully overwritten by each block's 16 loaded words.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
  end

  assign msg_mem_address = addr_q;
  assign msg_mem_enable  = en_q;
  assign w_out           = w_q;
  assign w_valid         = wv_q;
  assign k_addr          = cnt_q[5:0];
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: table of blocks plus start/reset corner sequences,
// checked cycle by cycle against an array-based schedule model.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] msg_mem_data = '0;
  logic [3:0]  msg_mem_address;
  logic        msg_mem_enable;
  logic [31:0] w_out;
  logic        w_valid;
  logic [5:0]  k_addr;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem  [16];
  logic [31:0] refw [64];
  logic [31:0] got  [64];

  typedef struct {
    logic [15:0][31:0] m;
    logic [31:0]       w16;
    logic [31:0]       w17;
    bit                has_exp;
  } vec_t;

  vec_t vecs [4];

  sha256_msg_schedule dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .msg_mem_data    (msg_mem_data),
    .msg_mem_address (msg_mem_address),
    .msg_mem_enable  (msg_mem_enable),
    .w_out           (w_out),
    .w_valid         (w_valid),
    .k_addr          (k_addr),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Synchronous message memory: data one cycle after address/enable.
  always @(posedge clk) if (msg_mem_enable) msg_mem_data <= mem[msg_mem_address];

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic compute_ref(input logic [15:0][31:0] m);
    for (int t = 0; t < 64; t++)
      refw[t] = (t < 16) ? m[t] : s1(refw[t-2]) + refw[t-7] + s0(refw[t-15]) + refw[t-16];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Start a block at cycle S and check every output through S+68 (or the reset abort).
  task automatic run_block(input logic [15:0][31:0] m, input bit p30, input bit h67,
                           input bit chain, input bit abort);
    for (int i = 0; i < 16; i++) mem[i] = m[i];
    compute_ref(m);
    if (!start) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      if (abort && k == 31) begin
        reset = 1'b0;
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        chk("rst_enable", 32'(msg_mem_enable), 32'd0);
        chk("rst_k_addr", 32'(k_addr), 32'd0);
        break;
      end
      chk("enable", 32'(msg_mem_enable), 32'(k <= 16));
      if (k <= 16) chk("address", 32'(msg_mem_address), 32'(k - 1));
      chk("w_valid", 32'(w_valid), 32'(k >= 3 && k <= 66));
      if (k >= 3 && k <= 66) begin
        got[k-3] = w_out;
        chk($sformatf("W%0d", k - 3), w_out, refw[k-3]);
      end
      if (k >= 2 && k <= 65) chk("k_addr", 32'(k_addr), 32'(k - 2));
      chk("done", 32'(done), 32'(k == 67));
      chk("busy", 32'(busy), 32'(k <= 67));
      start = (p30 && k == 30) || (h67 && k == 67) || (chain && k == 68);
      if (abort && k == 30) reset = 1'b1;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_w_valid", 32'(w_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  logic [15:0][31:0] abc, rnd_a, rnd_b;

  initial begin
    abc = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) begin
      rnd_a[i] = $urandom;
      rnd_b[i] = $urandom;
    end

    vecs[0] = '{m: abc, w16: 32'h61626380, w17: 32'h000F0000, has_exp: 1'b1};
    vecs[1] = '{m: {16{32'hFFFFFFFF}}, w16: 32'h203FFFFC, w17: 32'h203FFFFC, has_exp: 1'b1};
    vecs[2] = '{m: rnd_a, w16: 32'h0, w17: 32'h0, has_exp: 1'b0};
    vecs[3] = '{m: rnd_b, w16: 32'h0, w17: 32'h0, has_exp: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_w_out", w_out, 32'd0);
    chk("reset_w_valid", 32'(w_valid), 32'd0);
    chk("reset_enable", 32'(msg_mem_enable), 32'd0);
    chk("reset_address", 32'(msg_mem_address), 32'd0);
    chk("reset_k_addr", 32'(k_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    idle_check(2);

    foreach (vecs[v]) begin
      run_block(vecs[v].m, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tbl_W0", got[0], vecs[v].m[0]);
      if (vecs[v].has_exp) begin
        chk("tbl_W16", got[16], vecs[v].w16);
        chk("tbl_W17", got[17], vecs[v].w17);
      end
      idle_check(3);
    end

    // Ignored starts during EXPAND and DONE, then back-to-back different blocks.
    run_block(abc, 1'b1, 1'b1, 1'b1, 1'b0);
    run_block(rnd_a, 1'b0, 1'b0, 1'b1, 1'b0);
    run_block(abc, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check(2);

    // Reset in the middle of expansion, then a clean "abc" block.
    run_block(rnd_b, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_check(5);
    run_block(abc, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_W17", got[17], 32'h000F0000);
    idle_check(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
